// File: rtl/mux_pkg.sv
// Shared definitions for the scanning N:1 multiplexer.
//   MODE_MANUAL / MODE_AUTO : encodings of the `mode` input.
//   clog2_min1()            : ceil(log2(n)), but never less than 1, so that
//                             register widths stay legal for tiny parameters.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_nto1_dwell_timer.sv
// Dwell timer for the auto-scan mode: counts 0..DWELL-1 while enabled and
// flags the last cycle of each dwell period.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : synchronous reset, active-low
//   en      : count enable (auto mode and not held)
//   clr     : clear the count (manual mode); wins over en
//   tick    : high when count = DWELL-1 and en = 1 (one per dwell period)
module dwell_timer
  import mux_pkg::*;
#(
  parameter int DWELL = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = clog2_min1(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] count;

  // The wrap happens by compare, so the counter can never overflow.
  assign tick = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_nto1.sv
// Registered N-channel, W-bit multiplexer with manual or auto-scan selection.
// Ports:
//   clk       : system clock, rising edge
//   reset_n   : synchronous reset, active-low (clears all outputs)
//   data_in   : NCH packed channels, channel k at [k*W +: W]
//   sel       : manual channel select (values >= NCH are ignored)
//   mode      : 0 = manual, 1 = auto-scan
//   hold      : auto mode only, freezes the channel and the dwell count
//   dout      : registered data of the current channel
//   ch_out    : current channel (registered)
//   ch_change : one-cycle pulse in the cycle ch_out takes a new value
module mux_scan_nto1
  import mux_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int W     = 1,
  parameter int DWELL = 50_000_000,
  localparam int SELW = clog2_min1(NCH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NCH*W-1:0] data_in,
  input  logic [SELW-1:0]  sel,
  input  logic             mode,
  input  logic             hold,
  output logic [W-1:0]     dout,
  output logic [SELW-1:0]  ch_out,
  output logic             ch_change
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  logic            tick;
  logic            sel_ok;
  logic [SELW-1:0] cur_ch;
  logic [SELW-1:0] next_ch;

  dwell_timer #(
    .DWELL(DWELL)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (mode && !hold),
    .clr    (mode == MODE_MANUAL),
    .tick   (tick)
  );

  // Only matters for non-power-of-two NCH, where sel can name a missing channel.
  assign sel_ok = (int'(sel) < NCH);

  always_comb begin
    next_ch = cur_ch;
    if (mode == MODE_MANUAL) begin
      if (sel_ok) begin
        next_ch = sel;
      end
    end else if (tick) begin
      next_ch = (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
    end
  end

  // Stage 1: channel register. Stage 2: data register driven from the
  // registered channel, hence sel -> dout takes two cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_ch    <= '0;
      ch_change <= 1'b0;
      dout      <= '0;
    end else begin
      cur_ch    <= next_ch;
      ch_change <= (next_ch != cur_ch);
      dout      <= data_in[int'(cur_ch) * W +: W];
    end
  end

  assign ch_out = cur_ch;

endmodule

// File: tb/tb_mux_scan_nto1.sv
module tb_mux_scan_nto1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data_in;
  logic [1:0]  sel;
  logic        mode;
  logic        hold;
  logic [3:0]  dout;
  logic [1:0]  ch_out;
  logic        ch_change;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] ch;
    logic       chg;
    logic [3:0] d;
  } exp_t;

  exp_t sb[$];

  mux_scan_nto1 #(
    .NCH  (4),
    .W    (4),
    .DWELL(3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .data_in  (data_in),
    .sel      (sel),
    .mode     (mode),
    .hold     (hold),
    .dout     (dout),
    .ch_out   (ch_out),
    .ch_change(ch_change)
  );

  always #5 clk = ~clk;

  // Push the expected post-edge outputs for the inputs currently driven,
  // then clock once and compare what the DUT produced against the queue head.
  task automatic step(input string tag, input logic [1:0] ch, input logic chg,
                      input logic [3:0] d);
    exp_t e;
    e.ch = ch; e.chg = chg; e.d = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (ch_out === e.ch) else begin
      errors++;
      $error("FAIL %s ch_out got %0d want %0d", tag, ch_out, e.ch);
    end
    checks++;
    assert (ch_change === e.chg) else begin
      errors++;
      $error("FAIL %s ch_change got %0b want %0b", tag, ch_change, e.chg);
    end
    checks++;
    assert (dout === e.d) else begin
      errors++;
      $error("FAIL %s dout got %h want %h", tag, dout, e.d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    data_in = 16'hDCBA;
    sel     = 2'd0;
    mode    = 1'b0;
    hold    = 1'b0;

    // Reset held two cycles
    step("rst0", 2'd0, 1'b0, 4'h0);
    step("rst1", 2'd0, 1'b0, 4'h0);
    reset_n = 1'b1;
    step("rel0", 2'd0, 1'b0, 4'hA);
    step("rel1", 2'd0, 1'b0, 4'hA);

    // Manual select 0 -> 2, then rewrite the same value
    sel = 2'd2;
    step("man_t1", 2'd2, 1'b1, 4'hA);
    step("man_t2", 2'd2, 1'b0, 4'hC);
    step("man_same", 2'd2, 1'b0, 4'hC);
    sel = 2'd0;
    step("man_back0", 2'd0, 1'b1, 4'hC);
    step("man_back1", 2'd0, 1'b0, 4'hA);

    // Auto scan from ch0: 0,1,2,3,0 each lasting 3 cycles
    mode = 1'b1;
    step("auto_c0a", 2'd0, 1'b0, 4'hA);
    step("auto_c0b", 2'd0, 1'b0, 4'hA);
    step("auto_c1a", 2'd1, 1'b1, 4'hA);
    step("auto_c1b", 2'd1, 1'b0, 4'hB);
    step("auto_c1c", 2'd1, 1'b0, 4'hB);
    step("auto_c2a", 2'd2, 1'b1, 4'hB);
    step("auto_c2b", 2'd2, 1'b0, 4'hC);
    step("auto_c2c", 2'd2, 1'b0, 4'hC);
    step("auto_c3a", 2'd3, 1'b1, 4'hC);
    step("auto_c3b", 2'd3, 1'b0, 4'hD);
    step("auto_c3c", 2'd3, 1'b0, 4'hD);
    step("auto_w0a", 2'd0, 1'b1, 4'hD);
    step("auto_w0b", 2'd0, 1'b0, 4'hA);
    step("auto_w0c", 2'd0, 1'b0, 4'hA);
    step("auto_h1a", 2'd1, 1'b1, 4'hA);
    step("auto_h1b", 2'd1, 1'b0, 4'hB);

    // Hold for 5 cycles at count = 1 on ch1
    hold = 1'b1;
    for (int i = 0; i < 5; i++) step("hold", 2'd1, 1'b0, 4'hB);
    hold = 1'b0;
    step("unhold1", 2'd1, 1'b0, 4'hB);
    step("unhold2", 2'd2, 1'b1, 4'hB);
    step("post_h2a", 2'd2, 1'b0, 4'hC);
    step("post_h2b", 2'd2, 1'b0, 4'hC);
    step("post_h3a", 2'd3, 1'b1, 4'hC);
    step("post_h3b", 2'd3, 1'b0, 4'hD);
    step("post_h3c", 2'd3, 1'b0, 4'hD);
    step("post_h0a", 2'd0, 1'b1, 4'hD);
    step("post_h0b", 2'd0, 1'b0, 4'hA);
    step("post_h0c", 2'd0, 1'b0, 4'hA);
    step("post_h1a", 2'd1, 1'b1, 4'hA);
    step("post_h1b", 2'd1, 1'b0, 4'hB);

    // Auto -> manual mid-dwell on ch1 with sel = 3
    mode = 1'b0;
    sel  = 2'd3;
    step("a2m_a", 2'd3, 1'b1, 4'hB);
    step("a2m_b", 2'd3, 1'b0, 4'hD);

    // Back to auto: ch0 appears exactly 3 cycles after mode rises
    mode = 1'b1;
    step("m2a_1", 2'd3, 1'b0, 4'hD);
    step("m2a_2", 2'd3, 1'b0, 4'hD);
    step("m2a_3", 2'd0, 1'b1, 4'hD);
    step("m2a_0b", 2'd0, 1'b0, 4'hA);
    step("m2a_0c", 2'd0, 1'b0, 4'hA);
    step("m2a_1a", 2'd1, 1'b1, 4'hA);
    step("m2a_1b", 2'd1, 1'b0, 4'hB);
    step("m2a_1c", 2'd1, 1'b0, 4'hB);
    step("m2a_2a", 2'd2, 1'b1, 4'hB);
    step("m2a_2b", 2'd2, 1'b0, 4'hC);
    step("m2a_2c", 2'd2, 1'b0, 4'hC);

    // One-cycle reset mid-scan on ch2 at count = 2
    reset_n = 1'b0;
    step("mid_rst", 2'd0, 1'b0, 4'h0);
    reset_n = 1'b1;
    step("rs_0b", 2'd0, 1'b0, 4'hA);
    step("rs_0c", 2'd0, 1'b0, 4'hA);
    step("rs_1a", 2'd1, 1'b1, 4'hA);

    // Manual write of the current channel, then a data-only change
    mode = 1'b0;
    sel  = 2'd1;
    step("man_nochg", 2'd1, 1'b0, 4'hB);
    data_in = 16'hDC5A;
    step("data_lat", 2'd1, 1'b0, 4'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
